// File: rtl/id_imm_ctrl.sv
// Decode/immediate-select stage buffer: two-entry (output + skid) FIFO with opcode decode.
// Latency: 1 cycle from accept to out_* when empty or issuing the same cycle.
// Backpressure: in_ready is registered (state != FULL); out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       fetch-side handshake carrying in_inst, in_pc
//   flush                   drop everything held and the instruction offered this cycle
//   out_valid/out_ready     execute-side handshake carrying out_inst, out_pc, out_immSel, out_illegal
//   issue_cnt               completed out handshakes, wraps modulo 2^CNT_W
module id_imm_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [2:0]       out_immSel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    // Immediate-format select codes understood by the immediate generator.
    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_J    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        ill;
    } slot_t;

    // What the output register shows while nothing is held.
    localparam slot_t IDLE_SLOT = slot_t'({NOP_INST, 32'd0, IMM_I, 1'b0});

    state_t state;
    slot_t  out_q;
    slot_t  skid_q;

    logic accept;
    logic issue;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

    assign out_inst    = out_q.inst;
    assign out_pc      = out_q.pc;
    assign out_immSel  = out_q.sel;
    assign out_illegal = out_q.ill;

    // Decode is done on the way into storage so it is registered with the word.
    // Every legal opcode ends in 2'b11, so a compressed/garbage low pair falls to default.
    function automatic slot_t decode(input logic [31:0] inst, input logic [31:0] pc);
        slot_t s;
        s.inst = inst;
        s.pc   = pc;
        s.ill  = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011: s.sel = IMM_I;
            7'b0100011:             s.sel = IMM_S;
            7'b1100011:             s.sel = IMM_B;
            7'b1101111:             s.sel = IMM_J;
            7'b0110111, 7'b0010111: s.sel = IMM_U;
            7'b0110011:             s.sel = IMM_NONE;
            default: begin
                s.sel = IMM_NONE;
                s.ill = 1'b1;
            end
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_q     <= IDLE_SLOT;
            skid_q    <= IDLE_SLOT;
            issue_cnt <= '0;
        end else begin
            // An issue coinciding with a flush was still consumed downstream.
            if (issue) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end

            if (flush) begin
                state     <= EMPTY;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_q     <= IDLE_SLOT;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            out_q     <= decode(in_inst, in_pc);
                            out_valid <= 1'b1;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && !issue) begin
                            skid_q   <= decode(in_inst, in_pc);
                            in_ready <= 1'b0;
                            state    <= FULL;
                        end else if (issue && !accept) begin
                            out_q     <= IDLE_SLOT;
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end else if (issue && accept) begin
                            out_q <= decode(in_inst, in_pc);
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so nothing can be accepted.
                        if (issue) begin
                            out_q    <= skid_q;
                            in_ready <= 1'b1;
                            state    <= ONE;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_q     <= IDLE_SLOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id_imm_ctrl.sv
module tb_id_imm_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_inst;
    logic [31:0]   in_pc;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic [2:0]    out_immSel;
    logic          out_illegal;
    logic [CW-1:0] issue_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_imm_ctrl #(.NOP_INST(NOP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_immSel(out_immSel),
        .out_illegal(out_illegal), .issue_cnt(issue_cnt)
    );

    // ---------------- reference model: a bounded queue of accepted words ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t         mq[$];
    int unsigned   m_cnt;      // total issues since reset, unbounded
    int unsigned   m_issues;   // issues seen by the model, for scenario bookkeeping

    // Expected {illegal, immSel} from the opcode table.
    function automatic logic [3:0] ref_dec(input logic [31:0] inst);
        if (inst[1:0] != 2'b11) return 4'b1111;
        case (inst[6:2])
            5'b00100, 5'b00000, 5'b11001, 5'b11100: return 4'b0000;
            5'b01000:                               return 4'b0001;
            5'b11000:                               return 4'b0010;
            5'b11011:                               return 4'b0011;
            5'b01101, 5'b00101:                     return 4'b0100;
            5'b01100:                               return 4'b0111;
            default:                                return 4'b1111;
        endcase
    endfunction

    function automatic logic [CW-1:0] m_cnt_w();
        return CW'(m_cnt % (1 << CW));
    endfunction

    // Advance one clock; model applies the handshake rules to the inputs present at the edge.
    task automatic tick();
        bit iss, acc;
        item_t it;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            iss = (mq.size() > 0) && out_ready;
            acc = in_valid && (mq.size() < 2);
            if (iss) begin
                m_cnt++;
                m_issues++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (iss) void'(mq.pop_front());
                if (acc) begin
                    it.inst = in_inst;
                    it.pc   = in_pc;
                    mq.push_back(it);
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({in_ready, out_valid, out_inst, out_pc, out_immSel, out_illegal, issue_cnt} !==
            {1'b1, 1'b0, NOP, 32'h0, 3'd0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b inst=%h pc=%h sel=%0d ill=%b cnt=%0d, want rdy=1 vld=0 inst=%h pc=0 sel=0 ill=0 cnt=0",
                     in_ready, out_valid, out_inst, out_pc, out_immSel, out_illegal, issue_cnt, NOP);
        end
    endtask

    task automatic test_addi();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 32'h100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, out_inst, out_pc, out_immSel, out_illegal} !== {1'b1, 32'h00A00093, 32'h100, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_out: vld=%b inst=%h pc=%h sel=%0d ill=%b, want 1 00a00093 00000100 0 0",
                     out_valid, out_inst, out_pc, out_immSel, out_illegal);
        end
        tick();
        n_tests++;
        if ({issue_cnt, out_valid} !== {4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_cnt: cnt=%0d vld=%b, want cnt=1 vld=0", issue_cnt, out_valid);
        end
    endtask

    task automatic test_stall_order();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00112023; in_pc = 32'h200;
        tick();
        in_inst = 32'h0000006F; in_pc = 32'h204;
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_inst, out_immSel} !== {1'b0, 1'b1, 32'h00112023, 3'd1}) begin
            n_fail++;
            $display("FAIL stall_full: rdy=%b vld=%b inst=%h sel=%0d, want rdy=0 vld=1 inst=00112023 sel=1",
                     in_ready, out_valid, out_inst, out_immSel);
        end
        in_inst = 32'h00A00093; in_pc = 32'h208;   // stalled third offer, never accepted
        tick();
        n_tests++;
        if ({in_ready, out_inst} !== {1'b0, 32'h00112023}) begin
            n_fail++;
            $display("FAIL stall_hold: rdy=%b inst=%h, want rdy=0 inst=00112023", in_ready, out_inst);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_inst, out_pc, out_immSel} !== {1'b1, 1'b1, 32'h0000006F, 32'h204, 3'd3}) begin
            n_fail++;
            $display("FAIL stall_jal: rdy=%b vld=%b inst=%h pc=%h sel=%0d, want 1 1 0000006f 00000204 3",
                     in_ready, out_valid, out_inst, out_pc, out_immSel);
        end
        tick();
        n_tests++;
        if ({out_valid, issue_cnt} !== {1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL stall_drain: vld=%b cnt=%0d, want vld=0 cnt=2", out_valid, issue_cnt);
        end
    endtask

    task automatic test_decode();
        logic [31:0] tbl [6];
        logic [3:0]  want [6];
        tbl[0] = 32'hFFFFFFFF; want[0] = 4'b1111;
        tbl[1] = 32'h00208463; want[1] = 4'b0010;
        tbl[2] = 32'h12345037; want[2] = 4'b0100;
        tbl[3] = 32'h002081B3; want[3] = 4'b0111;   // add: no immediate, legal
        tbl[4] = 32'h00000010; want[4] = 4'b1111;   // low bits not 2'b11
        tbl[5] = 32'h00002003; want[5] = 4'b0000;   // lw
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_inst = tbl[i]; in_pc = 32'h300 + 4 * i;
            tick();
            in_valid = 1'b0;
            n_tests++;
            if ({out_valid, out_inst, out_illegal, out_immSel} !== {1'b1, tbl[i], want[i]}) begin
                n_fail++;
                $display("FAIL decode[%0d]: vld=%b inst=%h ill=%b sel=%0d, want vld=1 inst=%h ill=%b sel=%0d",
                         i, out_valid, out_inst, out_illegal, out_immSel, tbl[i], want[i][3], want[i][2:0]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [CW-1:0] cnt0;
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00100093; tick();
        in_inst = 32'h00200093; tick();
        cnt0 = issue_cnt;
        flush = 1'b1; in_inst = 32'h00300093;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if ({out_valid, in_ready, out_inst, out_pc} !== {1'b0, 1'b1, NOP, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_full: vld=%b rdy=%b inst=%h pc=%h, want vld=0 rdy=1 inst=%h pc=0",
                     out_valid, in_ready, out_inst, out_pc, NOP);
        end
        out_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if ({out_valid, issue_cnt} !== {1'b0, cnt0}) begin
            n_fail++;
            $display("FAIL flush_noissue: vld=%b cnt=%0d, want vld=0 cnt=%0d", out_valid, issue_cnt, cnt0);
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        m_issues = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_inst = 32'h00000093 | (i << 20); in_pc = 4 * i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if ({issue_cnt, out_valid} !== {4'd1, 1'b0} || m_issues != 17) begin
            n_fail++;
            $display("FAIL wrap17: cnt=%0d vld=%b (model issues %0d), want cnt=1 vld=0 issues 17",
                     issue_cnt, out_valid, m_issues);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00112023; in_pc = 32'h40; tick();
        in_inst = 32'hFFFFFFFF; in_pc = 32'h44; tick();
        out_ready = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if ({in_ready, out_valid, out_inst, out_pc, out_immSel, out_illegal, issue_cnt} !==
            {1'b1, 1'b0, NOP, 32'h0, 3'd0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_full: rdy=%b vld=%b inst=%h pc=%h sel=%0d ill=%b cnt=%0d, want 1 0 %h 0 0 0 0",
                     in_ready, out_valid, out_inst, out_pc, out_immSel, out_illegal, issue_cnt, NOP);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] e_inst, e_pc;
        logic [3:0]  e_dec;
        logic        e_vld;
        int          errs = 0;
        pool[0] = 32'h00000013; pool[1] = 32'h00000023; pool[2] = 32'h00000063; pool[3] = 32'h0000006F;
        pool[4] = 32'h00000037; pool[5] = 32'h00000033; pool[6] = 32'h00000067; pool[7] = 32'h0000007B;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst_n     = ($urandom_range(0, 150) != 0);
            in_inst   = ($urandom() & 32'hFFFF_FF80) | pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) in_inst = $urandom();
            in_pc     = $urandom();
            tick();
            e_vld  = (mq.size() > 0);
            e_inst = e_vld ? mq[0].inst : NOP;
            e_pc   = e_vld ? mq[0].pc : 32'h0;
            e_dec  = e_vld ? ref_dec(mq[0].inst) : 4'b0000;
            n_tests++;
            if ({in_ready, out_valid, out_inst, out_pc, out_illegal, out_immSel, issue_cnt} !==
                {(mq.size() < 2), e_vld, e_inst, e_pc, e_dec, m_cnt_w()}) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: rdy=%b vld=%b inst=%h pc=%h ill=%b sel=%0d cnt=%0d, want rdy=%b vld=%b inst=%h pc=%h ill=%b sel=%0d cnt=%0d",
                             c, in_ready, out_valid, out_inst, out_pc, out_illegal, out_immSel, issue_cnt,
                             (mq.size() < 2), e_vld, e_inst, e_pc, e_dec[3], e_dec[2:0], m_cnt_w());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_cnt = 0;
        m_issues = 0;
        test_reset();
        test_addi();
        test_stall_order();
        test_decode();
        test_flush();
        test_back_to_back_wrap();
        test_reset_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_imm_ctrl.md
ID_IMM_CTRL -- requirements
Module: id_imm_ctrl

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0013, instruction value driven on out_inst while out_valid is low.
REQ-002 Parameter CNT_W, default 16, width of the issued-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  fetch stage offers in_inst/in_pc.
REQ-006 in_inst  input  32  fetched instruction word.
REQ-007 in_pc  input  32  PC of in_inst.
REQ-008 in_ready  output  1  block accepts an instruction this cycle.
REQ-009 flush  input  1  discard all held and in-flight instructions.
REQ-010 out_valid  output  1  decoded instruction available to execute stage.
REQ-011 out_ready  input  1  execute stage consumes the instruction this cycle.
REQ-012 out_inst  output  32  held instruction, fed to the immediate generator inst port.
REQ-013 out_pc  output  32  PC of out_inst.
REQ-014 out_immSel  output  3  immediate-format select for the immediate generator, ImmSel_* codes of common_define.h.
REQ-015 out_illegal  output  1  held instruction has an unsupported opcode.
REQ-016 issue_cnt  output  CNT_W  count of completed out handshakes.

Function
REQ-017 Transfer occurs on in_valid&in_ready (accept) or out_valid&out_ready (issue), sampled at the rising edge.
REQ-018 Storage: one output register plus one skid register; FSM states EMPTY (0 held), ONE (output reg held), FULL (both held).
REQ-019 in_ready SHALL be registered and equal (state != FULL); no combinational path from out_ready to in_ready.
REQ-020 EMPTY: accept -> ONE, data into output reg; otherwise stay.
REQ-021 ONE: accept without issue -> FULL, data into skid reg; issue without accept -> EMPTY; accept and issue -> ONE, new data into output reg.
REQ-022 FULL: issue -> ONE, skid reg moves to output reg; no accept possible; otherwise stay.
REQ-023 Latency: accepted instruction appears on out_* the cycle after acceptance when the block was EMPTY or issued the same cycle; order strictly FIFO.
REQ-024 out_valid SHALL be 1 exactly in states ONE and FULL; outputs SHALL hold stable while out_valid&!out_ready.
REQ-025 Decode on opcode inst[6:0], registered alongside the instruction: 0010011, 0000011, 1100111, 1110011 -> ImmSel_I; 0100011 -> ImmSel_S; 1100011 -> ImmSel_B; 1101111 -> ImmSel_J; 0110111, 0010111 -> ImmSel_U; 0110011 -> 3'd7 (no immediate, generator outputs 0).
REQ-026 Any other opcode, or inst[1:0] != 2'b11, SHALL set out_illegal=1 and out_immSel=3'd7; the instruction is still issued normally.
REQ-027 When out_valid=0: out_inst=NOP_INST, out_pc=0, out_immSel=ImmSel_I, out_illegal=0.
REQ-028 flush=1: next state EMPTY, in_ready=1 next cycle; instruction offered in the flush cycle is dropped; an issue in the flush cycle still counts.
REQ-029 issue_cnt increments by 1 per issue, wraps modulo 2^CNT_W from all-ones to 0.
REQ-030 Flush has priority over accept; reset has priority over flush.

Reset
REQ-031 rst_n=0 at a rising edge: state EMPTY, in_ready=1, out_valid=0, issue_cnt=0, out_* per REQ-027, next cycle.
REQ-032 Reset asserted mid-transfer SHALL discard all held instructions; no handshake completes in a reset cycle.

Verification
REQ-033 Reset then in_inst=32'h00A00093 (addi) valid, out_ready=1 -> next cycle out_valid=1, out_immSel=ImmSel_I, out_illegal=0; following cycle issue_cnt=1.
REQ-034 out_ready=0, offer 32'h00112023 (sw) then 32'h0000006F (jal) -> FULL, in_ready=0; third offer stalls; raise out_ready -> sw (ImmSel_S) then jal (ImmSel_J) in order, none lost.
REQ-035 Offer 32'hFFFFFFFF -> out_illegal=1, out_immSel=3'd7; 32'h00208463 (beq) -> ImmSel_B; 32'h12345037 (lui) -> ImmSel_U.
REQ-036 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_inst=NOP_INST; flushed instructions never issue.
REQ-037 CNT_W=4, 17 back-to-back issues -> issue_cnt reads 1; random valid/ready throttling scoreboard -> FIFO order, no duplication.
REQ-038 rst_n=0 while FULL -> next cycle all outputs per REQ-031.
